regfile_ctrl: RTL and testbench
===============================

# regfile_ctrl

Access controller that sits in front of `regfile` and acts as its initiator. It accepts read/write requests over a valid/ready handshake, drives the register file's `addr`/`d_in`/`we_` inputs from registers, and returns read data over a valid/ready response channel. It also runs a zero-fill sweep of every entry after reset and on a clear request, so software always sees a known register state.

## Interface
- `ADDR_W`, default 5: address width; must match `regfile`.
- `DATA_W`, default 32: data width; must match `regfile`.
- `DATA_D`, default 32: number of entries; 1 ≤ `DATA_D` ≤ 2^`ADDR_W`.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset_` in 1: asynchronous, active-low reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: controller accepts a request this cycle.
- `req_we_` in 1: request type; 0 = write, 1 = read.
- `req_addr` in `ADDR_W`: request address.
- `req_wdata` in `DATA_W`: write data.
- `rsp_valid` out 1: read data valid.
- `rsp_ready` in 1: consumer takes the response.
- `rsp_rdata` out `DATA_W`: read data.
- `clear_` in 1: active-low request to zero-fill all entries, sampled in IDLE.
- `busy` out 1: high whenever the state is not IDLE.
- `rf_addr` out `ADDR_W`: to `regfile` `addr`; registered.
- `rf_d_in` out `DATA_W`: to `regfile` `d_in`; registered.
- `rf_we_` out 1: to `regfile` `we_`, active-low; registered.
- `rf_d_out` in `DATA_W`: from `regfile` `d_out`; combinational read.

## Operation
- States: CLEAR, IDLE, ACCESS, RESP.
- Reset values:
  - state = CLEAR, `rf_addr` = 0, `rf_we_` = 0, `rf_d_in` = 0.
  - `rsp_valid` = 0, `rsp_rdata` = 0, `busy` = 1, `req_ready` = 0.
  - `rf_we_` low during reset is harmless because `regfile` shares the same `reset_`.
- CLEAR:
  - `rf_we_` = 0 and `rf_d_in` = 0; entry `rf_addr` is written at every edge.
  - If `rf_addr` == `DATA_D`-1: `rf_we_` ← 1 and go to IDLE.
  - Otherwise `rf_addr` ← `rf_addr`+1.
  - Requests are not accepted.
- IDLE:
  - `req_ready` = `clear_` (combinational): high only in IDLE when `clear_` = 1.
  - If `clear_` = 0: `rf_addr` ← 0, `rf_we_` ← 0, `rf_d_in` ← 0, go to CLEAR. Clear has priority over a simultaneous `req_valid`, which stays pending.
  - Else if `req_valid`: `rf_addr` ← `req_addr`, `rf_d_in` ← `req_wdata`, and `rf_we_` ← `req_we_` when `req_addr` < `DATA_D`, else 1. Go to ACCESS.
- ACCESS (one cycle):
  - For a write, the `regfile` commits at the closing edge; `rf_we_` ← 1, go to IDLE. Writes produce no response.
  - For a read, `rsp_rdata` ← `rf_d_out` if `rf_addr` < `DATA_D`, else 0. Then `rsp_valid` ← 1, go to RESP.
- RESP:
  - `rsp_valid` and `rsp_rdata` are held stable until `rsp_ready` = 1 at an edge.
  - At that edge `rsp_valid` ← 0, go to IDLE.
- Out-of-range addresses (≥ `DATA_D`): the write is silently dropped (`rf_we_` stays 1); the read returns 0. The handshake completes normally in both cases.
- `rf_addr` never exceeds `DATA_D`-1 during CLEAR and does not wrap.
- `clear_` is ignored outside IDLE. A level held low re-triggers CLEAR each time IDLE is reached.

## Timing
- Reset release at edge E0 is the first rising edge with `reset_` high.
  - Entry k is zeroed at edge E0+k.
  - IDLE is reached after edge E0+`DATA_D`-1.
  - `req_ready` first rises in the following cycle.
- Clear from IDLE (accepted at edge C) takes `DATA_D`+1 edges: entry k is zeroed at C+1+k, and IDLE is reached after C+`DATA_D`.
- Write accepted at edge A: `rf_we_` is low in cycle A..A+1, the entry updates at A+1, and IDLE is reached after A+1.
- Read accepted at edge A: data is sampled at A+1 and `rsp_valid` is high from A+1.
  - With `rsp_ready` held high, `rsp_valid` drops at A+2.
  - Minimum read rate is one per 3 cycles; minimum write rate is one per 2 cycles.
- Read-after-write: the next request is accepted no earlier than A+2, so it always sees the new data.
- Async reset mid-operation aborts any state immediately: all outputs go to their reset values, any pending response is lost, and a fresh full CLEAR follows.

## Test plan
- Reset release, `DATA_D` = 32 -> `busy` high for 32 cycles, `rf_we_` low with `rf_addr` 0..31 in sequence, then `req_ready` = 1 and a read of any address returns 0.
- Write 0xDEADBEEF to addr 5, then read addr 5 -> write completes in 2 cycles, `rsp_rdata` = 0xDEADBEEF with `rsp_valid` high one edge after read accept.
- Read addr 3 with `rsp_ready` = 0 for 4 cycles -> `rsp_valid`/`rsp_rdata` held stable and `req_ready` = 0 throughout; the handshake completes on the cycle `rsp_ready` rises.
- `DATA_D` = 20: write 0x1234 to addr 25, then read addr 25 -> `rf_we_` never goes low, `rsp_rdata` = 0, and addr 25 mod 20 = 5 is unchanged.
- Fill addr 0..3 with nonzero data, pulse `clear_` low together with `req_valid` -> CLEAR wins; after `DATA_D`+1 cycles the pending request is accepted and reads of 0..3 return 0.
- Assert `reset_` low mid-CLEAR and during RESP -> `rsp_valid` = 0 immediately and all outputs return to reset values; after release a full 32-cycle sweep restarts from addr 0.

Source files
------------

// File: rtl/regfile_ctrl_if.sv
// Request/response channels between an initiator and the register-file controller.
// The master side issues requests and consumes read responses.
interface regfile_ctrl_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we_;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;

  modport master (
    output req_valid, req_we_, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we_, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/regfile_ctrl.sv
// Initiator in front of a register file: zero-fills every entry after reset or on clear,
// then serves single read/write requests with a held read response.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// S_CLEAR  | sweep rf_addr 0..DATA_D-1 writing zero, no requests taken
// S_IDLE   | ready for a request; clear_ low restarts the sweep
// S_ACCESS | one cycle on the regfile: write commits or read data sampled
// S_RESP   | read response held until rsp_ready
module regfile_ctrl #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int DATA_D = 32
) (
  input  logic              i_clk,
  input  logic              i_reset_,
  regfile_ctrl_if.slave     bus,
  input  logic              i_clear_,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_rf_addr,
  output logic [DATA_W-1:0] o_rf_d_in,
  output logic              o_rf_we_,
  input  logic [DATA_W-1:0] i_rf_d_out
);

  typedef enum logic [1:0] {S_CLEAR, S_IDLE, S_ACCESS, S_RESP} state_t;

  localparam logic [ADDR_W:0]   DEPTH = (ADDR_W+1)'(DATA_D);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(DATA_D - 1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_rf_addr;
  logic [DATA_W-1:0] r_rf_d_in;
  logic              r_rf_we_;
  logic              r_is_rd;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;

  logic w_req_in_range;
  logic w_rf_in_range;

  // Widened compares so DATA_D == 2**ADDR_W still works.
  assign w_req_in_range = ({1'b0, bus.req_addr} < DEPTH);
  assign w_rf_in_range  = ({1'b0, r_rf_addr} < DEPTH);

  assign bus.req_ready = (r_state == S_IDLE) && i_clear_;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign o_busy        = (r_state != S_IDLE);
  assign o_rf_addr     = r_rf_addr;
  assign o_rf_d_in     = r_rf_d_in;
  assign o_rf_we_      = r_rf_we_;

  always_ff @(posedge i_clk or negedge i_reset_) begin
    if (!i_reset_) begin
      r_state     <= S_CLEAR;
      r_rf_addr   <= '0;
      r_rf_d_in   <= '0;
      r_rf_we_    <= 1'b0;
      r_is_rd     <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          r_rf_we_  <= 1'b0;
          r_rf_d_in <= '0;
          if (r_rf_addr == LAST) begin
            r_rf_we_ <= 1'b1;
            r_state  <= S_IDLE;
          end else begin
            r_rf_addr <= r_rf_addr + 1'b1;
          end
        end
        S_IDLE: begin
          if (!i_clear_) begin
            r_rf_addr <= '0;
            r_rf_we_  <= 1'b0;
            r_rf_d_in <= '0;
            r_state   <= S_CLEAR;
          end else if (bus.req_valid) begin
            r_rf_addr <= bus.req_addr;
            r_rf_d_in <= bus.req_wdata;
            // Out-of-range writes are dropped by never pulling we_ low.
            r_rf_we_  <= w_req_in_range ? bus.req_we_ : 1'b1;
            r_is_rd   <= bus.req_we_;
            r_state   <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          r_rf_we_ <= 1'b1;
          if (r_is_rd) begin
            r_rsp_rdata <= w_rf_in_range ? i_rf_d_out : '0;
            r_rsp_valid <= 1'b1;
            r_state     <= S_RESP;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RESP: begin
          if (bus.rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_ctrl.sv
// Bench for regfile_ctrl with DATA_D = 20: a transaction-level model predicts every cycle's
// outputs into a queue that a single negedge process compares against the DUT.
module tb_regfile_ctrl;

  localparam int AW = 5;
  localparam int DW = 32;
  localparam int D  = 20;

  logic          clk = 1'b0;
  logic          reset_;
  logic          clear_;
  logic          busy;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_d_in;
  logic          rf_we_;
  logic [DW-1:0] rf_d_out;

  regfile_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  regfile_ctrl #(.ADDR_W(AW), .DATA_W(DW), .DATA_D(D)) dut (
    .i_clk      (clk),
    .i_reset_   (reset_),
    .bus        (bus),
    .i_clear_   (clear_),
    .o_busy     (busy),
    .o_rf_addr  (rf_addr),
    .o_rf_d_in  (rf_d_in),
    .o_rf_we_   (rf_we_),
    .i_rf_d_out (rf_d_out)
  );

  always #5 clk = ~clk;

  // Register file seen by the controller; starts full of garbage so the sweep matters.
  logic [DW-1:0] mem [D];
  always @(posedge clk)
    if (reset_ && !rf_we_ && int'(rf_addr) < D) mem[rf_addr] <= rf_d_in;
  assign rf_d_out = (int'(rf_addr) < D) ? mem[rf_addr] : 32'hBADBAD00;

  // Model state: what each entry must hold according to the access rules.
  logic [DW-1:0] exp_mem [D];

  typedef struct {
    logic [63:0]   tag;
    bit            busy, ready, we_, rv;
    bit            c_addr, c_din, c_rdata;
    logic [AW-1:0] addr;
    logic [DW-1:0] din, rdata;
  } exp_t;

  exp_t exp_q[$];
  exp_t ce;
  int   n_checks = 0;
  int   n_err    = 0;

  task automatic chk(input logic [63:0] tag, input string fld,
                     input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s.%s: got %0h, expected %0h (t=%0t)", tag, fld, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      ce = exp_q.pop_front();
      chk(ce.tag, "busy",      32'(busy),          32'(ce.busy));
      chk(ce.tag, "req_ready", 32'(bus.req_ready), 32'(ce.ready));
      chk(ce.tag, "rf_we_",    32'(rf_we_),        32'(ce.we_));
      chk(ce.tag, "rsp_valid", 32'(bus.rsp_valid), 32'(ce.rv));
      if (ce.c_addr)  chk(ce.tag, "rf_addr",   32'(rf_addr),   32'(ce.addr));
      if (ce.c_din)   chk(ce.tag, "rf_d_in",   rf_d_in,        ce.din);
      if (ce.c_rdata) chk(ce.tag, "rsp_rdata", bus.rsp_rdata,  ce.rdata);
    end
  end

  function automatic exp_t mk(input logic [63:0] tag, input bit b, input bit r,
                              input bit w, input bit v);
    exp_t e;
    e.tag = tag; e.busy = b; e.ready = r; e.we_ = w; e.rv = v;
    e.c_addr = 0; e.c_din = 0; e.c_rdata = 0;
    e.addr = '0; e.din = '0; e.rdata = '0;
    return e;
  endfunction

  task automatic step(input exp_t e);
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Inputs that the controller must ignore in its current state.
  task automatic rnd_ignored();
    bus.req_valid = 1'($urandom_range(0, 1));
    bus.req_we_   = 1'($urandom_range(0, 1));
    bus.req_addr  = AW'($urandom_range(0, 31));
    bus.req_wdata = $urandom;
    clear_        = ($urandom_range(0, 3) != 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.req_valid = 1'b0;
      clear_        = 1'b1;
      step(mk("idle", 0, 1, 1, 0));
    end
  endtask

  task automatic sweep(input int n, input bit rnd);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      if (rnd) rnd_ignored();
      e = mk("sweep", 1, 0, 0, 0);
      e.c_addr = 1; e.addr = AW'(k);
      e.c_din  = 1; e.din  = '0;
      step(e);
    end
    if (n == D) for (int k = 0; k < D; k++) exp_mem[k] = '0;
  endtask

  task automatic reset_abort(input int cyc);
    exp_t e;
    reset_ = 1'b0;
    for (int i = 0; i < cyc; i++) begin
      rnd_ignored();
      e = mk("reset", 1, 0, 0, 0);
      e.c_addr  = 1; e.addr  = '0;
      e.c_din   = 1; e.din   = '0;
      e.c_rdata = 1; e.rdata = '0;
      step(e);
    end
    reset_ = 1'b1;
  endtask

  task automatic clear_op(input bit pend, input logic [AW-1:0] a);
    clear_        = 1'b0;
    bus.req_valid = pend;
    bus.req_we_   = 1'b1;
    bus.req_addr  = a;
    step(mk("clr", 0, 0, 1, 0));
    clear_ = 1'b1;
    sweep(D, !pend);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    bit   inr;
    inr = (int'(a) < D);
    clear_        = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_we_   = 1'b0;
    bus.req_addr  = a;
    bus.req_wdata = d;
    step(mk("wr_acc", 0, 1, 1, 0));
    rnd_ignored();
    e = mk("wr_exe", 1, 0, !inr, 0);
    e.c_addr = 1; e.addr = a;
    if (inr) begin e.c_din = 1; e.din = d; end
    step(e);
    if (inr) exp_mem[a] = d;
  endtask

  task automatic rd(input logic [AW-1:0] a, input int stall, input int abort_at,
                    output logic [DW-1:0] ev);
    exp_t e;
    clear_        = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_we_   = 1'b1;
    bus.req_addr  = a;
    bus.req_wdata = $urandom;
    step(mk("rd_acc", 0, 1, 1, 0));
    rnd_ignored();
    e = mk("rd_exe", 1, 0, 1, 0);
    e.c_addr = 1; e.addr = a;
    step(e);
    ev = (int'(a) < D) ? exp_mem[a] : '0;
    for (int i = 0; i <= stall; i++) begin
      if (i == abort_at) begin
        reset_abort(2);
        sweep(D, 1);
        bus.rsp_ready = 1'b0;
        return;
      end
      rnd_ignored();
      bus.rsp_ready = (i == stall);
      e = mk("rd_rsp", 1, 0, 1, 1);
      e.c_rdata = 1; e.rdata = ev;
      step(e);
    end
    bus.rsp_ready = 1'b0;
  endtask

  task automatic rd_lit(input logic [AW-1:0] a, input int stall, input logic [DW-1:0] lit);
    logic [DW-1:0] ev;
    rd(a, stall, -1, ev);
    chk("pin", "model", ev, lit);
  endtask

  logic [DW-1:0] tmp;

  initial begin
    for (int k = 0; k < D; k++) begin
      mem[k]     = $urandom | 32'h1;
      exp_mem[k] = 'x;
    end
    reset_        = 1'b0;
    clear_        = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_we_   = 1'b1;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.rsp_ready = 1'b0;
    @(posedge clk);
    #1;

    // Power-up sweep, then basic accesses
    reset_abort(3);
    sweep(D, 1);
    idle(1);
    rd_lit(5'd7, 0, 32'h0);
    wr(5'd5, 32'hDEADBEEF);
    rd_lit(5'd5, 0, 32'hDEADBEEF);
    rd_lit(5'd3, 4, 32'h0);

    // Out-of-range: write dropped, read returns zero, aliased entry untouched
    wr(5'd25, 32'h1234);
    rd_lit(5'd25, 1, 32'h0);
    rd_lit(5'd5, 0, 32'hDEADBEEF);

    // Clear beats a simultaneous request, which is then served
    for (int k = 0; k < 4; k++) wr(AW'(k), 32'hA5A50000 | 32'(k + 1));
    rd_lit(5'd2, 0, 32'hA5A50003);
    clear_op(1'b1, 5'd2);
    rd_lit(5'd2, 0, 32'h0);
    rd_lit(5'd0, 0, 32'h0);
    rd_lit(5'd1, 0, 32'h0);
    rd_lit(5'd3, 0, 32'h0);

    // Reset during CLEAR and during RESP
    wr(5'd4, 32'h0BADF00D);
    clear_op(1'b0, 5'd0);
    wr(5'd6, 32'h600D600D);
    clear_        = 1'b0;
    bus.req_valid = 1'b0;
    step(mk("clr", 0, 0, 1, 0));
    clear_ = 1'b1;
    sweep(7, 1);
    reset_abort(2);
    sweep(D, 1);
    wr(5'd4, 32'h44444444);
    rd(5'd4, 5, 2, tmp);
    rd_lit(5'd4, 0, 32'h0);

    // Randomized traffic
    for (int t = 0; t < 300; t++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 4)       clear_op(1'($urandom_range(0, 1)), AW'($urandom_range(0, 31)));
      else if (r < 12) idle($urandom_range(1, 3));
      else if (r < 55) wr(AW'($urandom_range(0, 31)), $urandom);
      else             rd(AW'($urandom_range(0, 31)), $urandom_range(0, 3), -1, tmp);
    end

    idle(2);
    chk("end", "queue", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
